// File: rtl/enemy_ship_placer.sv
// Places CPU ships on the board from a random (row, col) stream; optional PLACER_FALLBACK_SCAN_EN adds a linear scan after RETRY_LIMIT rejects.
// Latency: start->busy 1 cycle, one candidate per cycle, best case target+1 cycles to done; q_hit is combinational.
// Backpressure: none; start is ignored while busy, and candidates are consumed every busy cycle.
module enemy_ship_placer #(
  parameter int ROWS        = 5,
  parameter int COLS        = 5,
  parameter int MAX_SHIPS   = 5,
  parameter int RETRY_LIMIT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2:0]           ship_count,
  input  logic [2:0]           i_random,
  input  logic [2:0]           j_random,
  input  logic [2:0]           q_i,
  input  logic [2:0]           q_j,
  output logic [ROWS*COLS-1:0] board,
  output logic                 q_hit,
  output logic [2:0]           placed_count,
  output logic                 busy,
  output logic                 done
);

  localparam int CELLS = ROWS * COLS;
  localparam int IDX_W = $clog2(CELLS);
  localparam logic [CELLS-1:0] CELL0 = {{(CELLS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLACE,
`ifdef PLACER_FALLBACK_SCAN_EN
    S_SCAN,
`endif
    S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [CELLS-1:0] board_nxt;
  logic [2:0]       placed_nxt;
  logic [2:0]       target, target_nxt, target_clamped;
  logic [IDX_W-1:0] cand_idx, q_idx;
  logic             cand_in_range, cand_ok, q_in_range;

`ifdef PLACER_FALLBACK_SCAN_EN
  localparam int RW = $clog2(RETRY_LIMIT + 1);
  logic [RW-1:0]    retry_cnt, retry_nxt;
  logic [IDX_W-1:0] scan_idx, scan_nxt;
`endif

  // Aliased indices for out-of-range coordinates are masked by the range flags.
  assign cand_in_range = (32'(i_random) < ROWS) && (32'(j_random) < COLS);
  assign cand_idx      = IDX_W'(i_random) * IDX_W'(COLS) + IDX_W'(j_random);
  assign cand_ok       = cand_in_range && !board[cand_idx];

  assign q_in_range = (32'(q_i) < ROWS) && (32'(q_j) < COLS);
  assign q_idx      = IDX_W'(q_i) * IDX_W'(COLS) + IDX_W'(q_j);
  assign q_hit      = q_in_range && board[q_idx];

  always_comb begin
    target_clamped = ship_count;
    if (ship_count == 3'd0)
      target_clamped = 3'd1;
    else if (32'(ship_count) > MAX_SHIPS)
      target_clamped = 3'(MAX_SHIPS);
  end

  always_comb begin
    state_nxt  = state;
    board_nxt  = board;
    placed_nxt = placed_count;
    target_nxt = target;
`ifdef PLACER_FALLBACK_SCAN_EN
    retry_nxt  = retry_cnt;
    scan_nxt   = scan_idx;
`endif
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          board_nxt  = '0;
          placed_nxt = 3'd0;
          target_nxt = target_clamped;
`ifdef PLACER_FALLBACK_SCAN_EN
          retry_nxt  = '0;
`endif
          state_nxt  = S_PLACE;
        end
      end
      S_PLACE: begin
        if (cand_ok) begin
          board_nxt  = board | (CELL0 << cand_idx);
          placed_nxt = placed_count + 3'd1;
`ifdef PLACER_FALLBACK_SCAN_EN
          retry_nxt  = '0;
`endif
          if (placed_nxt == target)
            state_nxt = S_DONE;
        end
`ifdef PLACER_FALLBACK_SCAN_EN
        else begin
          if (retry_cnt != RW'(RETRY_LIMIT))
            retry_nxt = retry_cnt + 1'b1;
          if (retry_nxt == RW'(RETRY_LIMIT)) begin
            scan_nxt  = '0;
            state_nxt = S_SCAN;
          end
        end
`endif
      end
`ifdef PLACER_FALLBACK_SCAN_EN
      S_SCAN: begin
        if (!board[scan_idx]) begin
          board_nxt  = board | (CELL0 << scan_idx);
          placed_nxt = placed_count + 3'd1;
          retry_nxt  = '0;
          state_nxt  = (placed_nxt == target) ? S_DONE : S_PLACE;
        end else begin
          scan_nxt = scan_idx + 1'b1;
        end
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      board        <= '0;
      placed_count <= 3'd0;
      target       <= 3'd0;
`ifdef PLACER_FALLBACK_SCAN_EN
      retry_cnt    <= '0;
      scan_idx     <= '0;
`endif
    end else begin
      state        <= state_nxt;
      board        <= board_nxt;
      placed_count <= placed_nxt;
      target       <= target_nxt;
`ifdef PLACER_FALLBACK_SCAN_EN
      retry_cnt    <= retry_nxt;
      scan_idx     <= scan_nxt;
`endif
    end
  end

`ifdef PLACER_FALLBACK_SCAN_EN
  assign busy = (state == S_PLACE) || (state == S_SCAN);
`else
  assign busy = (state == S_PLACE);
`endif
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_enemy_ship_placer.sv
// Bench for enemy_ship_placer: scripted tables, clamp sweep, corner sequences, and random stream vs a board-level model.
module tb_enemy_ship_placer;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [2:0]  ship_count, i_random, j_random, q_i, q_j;
  logic [24:0] board;
  logic        q_hit;
  logic [2:0]  placed_count;
  logic        busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  enemy_ship_placer dut (
    .clk(clk), .rst(rst), .start(start), .ship_count(ship_count),
    .i_random(i_random), .j_random(j_random), .q_i(q_i), .q_j(q_j),
    .board(board), .q_hit(q_hit), .placed_count(placed_count),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Board-level reference: 2D occupancy grid, ship tally and rejection streak.
  bit m_occ [0:4][0:4];
  int m_cnt, m_tgt, m_rej, m_scan_wait;
  bit m_busy, m_done, m_scanning;

  function automatic int lowest_free();
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        if (!m_occ[r][c]) return r * 5 + c;
    return -1;
  endfunction

  function automatic logic [24:0] model_board();
    logic [24:0] b = '0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        b[r*5+c] = m_occ[r][c];
    return b;
  endfunction

  task automatic model_start(input int sc);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        m_occ[r][c] = 1'b0;
    m_cnt = 0; m_rej = 0; m_scanning = 0; m_scan_wait = 0;
    m_tgt = (sc < 1) ? 1 : ((sc > 5) ? 5 : sc);
    m_busy = 1; m_done = 0;
  endtask

  task automatic model_take(input int r, input int c);
    m_occ[r][c] = 1'b1;
    m_cnt++;
    m_rej = 0;
    if (m_cnt == m_tgt) begin
      m_busy = 0;
      m_done = 1;
    end
  endtask

  task automatic model_edge(input int i, input int j);
    int k;
    if (m_busy) begin
      if (m_scanning) begin
        if (m_scan_wait == 0) begin
          k = lowest_free();
          m_scanning = 0;
          model_take(k / 5, k % 5);
        end else begin
          m_scan_wait--;
        end
      end else if (i < 5 && j < 5 && !m_occ[i][j]) begin
        model_take(i, j);
      end else begin
        if (m_rej < 8) m_rej++;
`ifdef PLACER_FALLBACK_SCAN_EN
        if (m_rej == 8) begin
          m_scanning  = 1;
          m_scan_wait = lowest_free();
        end
`endif
      end
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_board"}, 32'(board), 32'(model_board()));
    check({tag, "_cnt"},   32'(placed_count), 32'(m_cnt));
    check({tag, "_busy"},  32'(busy), 32'(m_busy));
    check({tag, "_done"},  32'(done), 32'(m_done));
  endtask

  task automatic do_start(input int sc);
    start      = 1'b1;
    ship_count = 3'(sc);
    tick();
    start = 1'b0;
    model_start(sc);
  endtask

  typedef struct {
    logic [2:0]  i, j;
    logic [24:0] board;
    logic [2:0]  cnt;
    logic        busy, done;
  } vec_t;

  vec_t tbl [5];
  int   exp_t [8];

  initial begin
    tbl[0] = '{i: 3'd1, j: 3'd2, board: 25'h0000080, cnt: 3'd1, busy: 1'b1, done: 1'b0};
    tbl[1] = '{i: 3'd1, j: 3'd2, board: 25'h0000080, cnt: 3'd1, busy: 1'b1, done: 1'b0};
    tbl[2] = '{i: 3'd4, j: 3'd4, board: 25'h1000080, cnt: 3'd2, busy: 1'b1, done: 1'b0};
    tbl[3] = '{i: 3'd5, j: 3'd0, board: 25'h1000080, cnt: 3'd2, busy: 1'b1, done: 1'b0};
    tbl[4] = '{i: 3'd0, j: 3'd0, board: 25'h1000081, cnt: 3'd3, busy: 1'b0, done: 1'b1};
    exp_t  = '{1, 1, 2, 3, 4, 5, 5, 5};

    rst = 1'b0; start = 1'b0; ship_count = 3'd0;
    i_random = 3'd0; j_random = 3'd0; q_i = 3'd0; q_j = 3'd0;
    m_busy = 0; m_done = 0; m_scanning = 0; m_cnt = 0; m_tgt = 0; m_rej = 0; m_scan_wait = 0;
    #12;
    check("rst_board", 32'(board), 0);
    check("rst_cnt", 32'(placed_count), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_qhit", 32'(q_hit), 0);
    rst = 1'b1;
    tick();
    tick();
    check("idle_board", 32'(board), 0);
    check("idle_busy", 32'(busy), 0);

    // Scripted stream with a duplicate and an out-of-range row.
    do_start(3);
    check("scr_busy0", 32'(busy), 1);
    for (int k = 0; k < 5; k++) begin
      i_random = tbl[k].i;
      j_random = tbl[k].j;
      tick();
      check($sformatf("scr%0d_board", k), 32'(board), 32'(tbl[k].board));
      check($sformatf("scr%0d_cnt", k), 32'(placed_count), 32'(tbl[k].cnt));
      check($sformatf("scr%0d_busy", k), 32'(busy), 32'(tbl[k].busy));
      check($sformatf("scr%0d_done", k), 32'(done), 32'(tbl[k].done));
    end
    i_random = 3'd3; j_random = 3'd3;
    tick();
    check("hold_board", 32'(board), 32'h1000081);
    check("hold_done", 32'(done), 1);

    // Clamp sweep, distinct cells from index 0 upward.
    for (int sc = 0; sc < 8; sc++) begin
      do_start(sc);
      for (int k = 0; k < exp_t[sc]; k++) begin
        i_random = 3'(k / 5);
        j_random = 3'(k % 5);
        tick();
        if (k < exp_t[sc] - 1) check($sformatf("clamp%0d_busy%0d", sc, k), 32'(busy), 1);
      end
      check($sformatf("clamp%0d_done", sc), 32'(done), 1);
      check($sformatf("clamp%0d_cnt", sc), 32'(placed_count), 32'(exp_t[sc]));
      check($sformatf("clamp%0d_board", sc), 32'(board), (32'd1 << exp_t[sc]) - 1);
    end

    // start during placement must not restart or retarget.
    do_start(3);
    i_random = 3'd0; j_random = 3'd0;
    tick();
    start = 1'b1; ship_count = 3'd1;
    i_random = 3'd0; j_random = 3'd1;
    tick();
    start = 1'b0;
    check("midstart_board", 32'(board), 32'h3);
    check("midstart_cnt", 32'(placed_count), 2);
    check("midstart_busy", 32'(busy), 1);
    i_random = 3'd0; j_random = 3'd2;
    tick();
    check("midstart_done", 32'(done), 1);
    check("midstart_cnt3", 32'(placed_count), 3);
    do_start(2);
    check("restart_board", 32'(board), 0);
    check("restart_cnt", 32'(placed_count), 0);
    check("restart_busy", 32'(busy), 1);
    check("restart_done", 32'(done), 0);

    // Queries, including a column that would alias onto the next row.
    i_random = 3'd2; j_random = 3'd3;
    tick();
    i_random = 3'd2; j_random = 3'd0;
    tick();
    check("q_board", 32'(board), 32'h2400);
    q_i = 3'd2; q_j = 3'd3; #1; check("q_2_3", 32'(q_hit), 1);
    q_i = 3'd5; q_j = 3'd3; #1; check("q_5_3", 32'(q_hit), 0);
    q_i = 3'd1; q_j = 3'd5; #1; check("q_1_5", 32'(q_hit), 0);
    q_i = 3'd2; q_j = 3'd0; #1; check("q_2_0", 32'(q_hit), 1);
    q_i = 3'd2; q_j = 3'd2; #1; check("q_2_2", 32'(q_hit), 0);

    // Asynchronous reset in the middle of a placement.
    do_start(4);
    i_random = 3'd1; j_random = 3'd1;
    tick();
    i_random = 3'd3; j_random = 3'd3;
    tick();
    q_i = 3'd1; q_j = 3'd1;
    #2;
    rst = 1'b0;
    #1;
    check("arst_board", 32'(board), 0);
    check("arst_cnt", 32'(placed_count), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_done", 32'(done), 0);
    check("arst_qhit", 32'(q_hit), 0);
    rst = 1'b1;
    tick();
    check("arst_idle", 32'(busy), 0);

`ifdef PLACER_FALLBACK_SCAN_EN
    do_start(2);
    i_random = 3'd2; j_random = 3'd2;
    tick();
    check("fb_first", 32'(board), 32'h1000);
    for (int r = 0; r < 8; r++) begin
      tick();
      check($sformatf("fb_rej%0d_busy", r), 32'(busy), 1);
      check($sformatf("fb_rej%0d_board", r), 32'(board), 32'h1000);
    end
    tick();
    check("fb_done", 32'(done), 1);
    check("fb_board", 32'(board), 32'h0001001);
    check("fb_cnt", 32'(placed_count), 2);
`endif

    // Random coordinate stream against the reference model.
    for (int run = 0; run < 30; run++) begin
      int cyc;
      do_start(int'($urandom_range(0, 7)));
      check_model("rnd_start");
      cyc = 0;
      while (m_busy && cyc < 500) begin
        i_random = 3'($urandom_range(0, 7));
        j_random = 3'($urandom_range(0, 7));
        tick();
        model_edge(int'(i_random), int'(j_random));
        check_model("rnd");
        q_i = 3'($urandom_range(0, 7));
        q_j = 3'($urandom_range(0, 7));
        #1;
        check("rnd_qhit", 32'(q_hit),
              32'((q_i < 5 && q_j < 5) ? m_occ[q_i][q_j] : 1'b0));
        cyc++;
      end
      if (m_busy) begin
        n_checks++;
        n_fail++;
        $display("FAIL rnd_timeout: run %0d still placing after %0d cycles, required completion", run, cyc);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/enemy_ship_placer.md
# enemy_ship_placer

Places the CPU fleet on the 5x5 battleship board. Consumes the per-cycle `i_random`/`j_random` coordinate stream from the random generator stage. Accepts only in-range, unoccupied cells, one ship per cell, until the requested ship count is reached. The resulting occupancy map feeds the VGA board renderer and the shot-resolution logic.

## Interface
- `ROWS`, default 5: board rows
- `COLS`, default 5: board columns
- `MAX_SHIPS`, default 5: upper clamp on ship count
- `RETRY_LIMIT`, default 8: consecutive rejections before fallback scan (only with the macro)

Ports:
- `clk`, in, 1: single clock; all state changes on its rising edge
- `rst`, in, 1: asynchronous, active-low reset
- `start`, in, 1: one-cycle pulse; begins a new placement
- `ship_count`, in, 3: requested ships (the player's ship count)
- `i_random`, in, 3: candidate row from the random generator
- `j_random`, in, 3: candidate column from the random generator
- `q_i`, in, 3: query row
- `q_j`, in, 3: query column
- `board`, out, 25: occupancy map; bit index = i*COLS + j
- `q_hit`, out, 1: combinational `board[q_i*COLS+q_j]`; 0 if q_i≥ROWS or q_j≥COLS
- `placed_count`, out, 3: ships placed so far
- `busy`, out, 1: high in PLACE/SCAN
- `done`, out, 1: high in DONE

## Operation
- States: IDLE, PLACE, SCAN (macro only), DONE.
- Reset (async, `rst`=0): state IDLE; `board`=0, `placed_count`=0, `busy`=0, `done`=0, retry counter 0, target 0.
- IDLE/DONE + `start`:
  - clear `board`, `placed_count`, retry counter
  - latch target = `ship_count` clamped to [1, MAX_SHIPS]; 0→1, 6/7→5
  - go to PLACE.
- PLACE, every cycle, sample (`i_random`, `j_random`):
  - reject if i≥ROWS or j≥COLS, or if the cell is already set; increment retry counter (saturating).
  - otherwise set the bit, increment `placed_count`, clear retry counter.
  - if this acceptance makes `placed_count` == target, go to DONE.
- DONE: hold `board` and `placed_count`; `done`=1 until next `start`.
- `start` while busy is ignored; no restart mid-placement.
- Rejection has no side effect on `board`.
- With target ≤ 25 free cells, placement always terminates when the fallback is compiled in.

## Timing
- `start` sampled at edge n → `busy`=1 after edge n; first coordinate sampled at edge n+1.
- An accepted coordinate sampled at edge k is visible in `board`/`placed_count` after edge k.
- Final acceptance at edge k → `done`=1 and `busy`=0 after edge k.
- Best case: latency from `start` to `done` = target+1 cycles.
- `q_hit` is combinational from `board`/`q_i`/`q_j`, with zero latency.
- Reset asserted mid-PLACE/SCAN returns all outputs to reset values immediately, without waiting for a clock edge.

## Configuration
- `PLACER_FALLBACK_SCAN_EN` defined:
  - When the retry counter reaches RETRY_LIMIT in PLACE, go to SCAN.
  - SCAN tests one cell per cycle, from index 0 ascending.
  - At the first free cell: set it, increment `placed_count`, clear the retry counter, then go to DONE if the target is met, else back to PLACE.
- Macro undefined:
  - No retry counter, no SCAN state.
  - PLACE retries indefinitely; termination depends on the generator's sequence.

## Test plan
- Reset check: `rst`=0 mid-run → `board`=0, `placed_count`=0, `busy`=0, `done`=0, `q_hit`=0.
- Scripted stream, `ship_count`=3, coordinates (1,2),(1,2),(4,4),(5,0),(0,0):
  - `board` = bits 7, 24, 0 set
  - duplicate and out-of-range rejected
  - `done` after 5th sample edge
  - `placed_count`=3.
- Clamps:
  - `ship_count`=0 → exactly 1 ship, then `done`
  - `ship_count`=7 → 5 ships.
- `start` pulsed during PLACE → ignored. After DONE, `start` clears `board` and restarts.
- Query: after placing (2,3), `q_i`=2,`q_j`=3 → `q_hit`=1; `q_i`=5 → `q_hit`=0.
- Fallback (macro on), constant (2,2), `ship_count`=2:
  - bit 12 set
  - after 8 rejections SCAN sets bit 0
  - `done`=1, `board`=0x0001001.
